// File: rtl/icache_responder_if.sv
// Bundles the CPU fetch port and the physical-memory burst port of the icache.
// The slave modport is the cache itself; master is the IF stage / memory side.
interface icache_responder_if #(
  parameter int BEAT_W = 64
);
  logic [31:0]       i_mem_addr;
  logic              i_mem_read;
  logic [31:0]       i_mem_rdata;
  logic              i_mem_resp;
  logic              inv;
  logic [31:0]       pmem_addr;
  logic              pmem_read;
  logic [BEAT_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_mem_addr, i_mem_read, inv, pmem_rdata, pmem_resp,
    output i_mem_rdata, i_mem_resp, pmem_addr, pmem_read
  );

  modport master (
    output i_mem_addr, i_mem_read, inv, pmem_rdata, pmem_resp,
    input  i_mem_rdata, i_mem_resp, pmem_addr, pmem_read
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache: combinational hits, 4-beat line refill.
// Line is 32 B (8 words, 4 x 64-bit beats); storage is in flops.
module icache_responder #(
  parameter int SET_BITS = 4,
  parameter int BEAT_W   = 64
) (
  input logic              clk,
  input logic              rst,
  icache_responder_if.slave bus
);
  localparam int NSETS = 1 << SET_BITS;
  localparam int TAG_W = 27 - SET_BITS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILL    = 2'd1;
  localparam logic [1:0] INSTALL = 2'd2;

  logic [1:0]            state;
  logic [1:0]            beat_cnt;
  logic [31:5]           fill_addr;
  logic                  inv_pend;
  logic [NSETS-1:0]      valid;
  logic [TAG_W-1:0]      tag_arr  [NSETS];
  logic [4*BEAT_W-1:0]   data_arr [NSETS];
  logic [3:0][BEAT_W-1:0] line_buf;

  logic [SET_BITS-1:0]   req_index;
  logic [TAG_W-1:0]      req_tag;
  logic [2:0]            req_word;
  logic [SET_BITS-1:0]   fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic [31:0]           sel_word;
  logic [1:0]            unused_addr_bits;

  assign req_index        = bus.i_mem_addr[4+SET_BITS:5];
  assign req_tag          = bus.i_mem_addr[31:5+SET_BITS];
  assign req_word         = bus.i_mem_addr[4:2];
  assign fill_index       = fill_addr[4+SET_BITS:5];
  assign fill_tag         = fill_addr[31:5+SET_BITS];
  assign unused_addr_bits = bus.i_mem_addr[1:0];

  assign hit      = bus.i_mem_read && valid[req_index] && (tag_arr[req_index] == req_tag);
  assign sel_word = data_arr[req_index][32*req_word +: 32];

  // Responses only come out of IDLE, so a fetch dropped during a refill never sees stale data.
  always_comb begin
    bus.i_mem_resp  = (state == IDLE) && hit;
    bus.i_mem_rdata = bus.i_mem_resp ? sel_word : '0;
    bus.pmem_read   = (state == FILL);
    bus.pmem_addr   = {fill_addr, 5'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      fill_addr <= '0;
      inv_pend  <= 1'b0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inv) valid <= '0;
          if (bus.i_mem_read && !hit) begin
            fill_addr <= bus.i_mem_addr[31:5];
            beat_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (bus.inv) inv_pend <= 1'b1;
          if (bus.pmem_resp) begin
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) state <= INSTALL;
          end
        end
        INSTALL: begin
          // An invalidate seen during the refill (or right now) wins over the install.
          if (inv_pend || bus.inv) begin
            valid    <= '0;
            inv_pend <= 1'b0;
          end else begin
            valid[fill_index] <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && bus.pmem_resp) line_buf[beat_cnt] <= bus.pmem_rdata;
    if (state == INSTALL) begin
      data_arr[fill_index] <= line_buf;
      tag_arr[fill_index]  <= fill_tag;
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: cold miss, hit streaming, conflict,
// dropped fetch during refill, invalidation and asynchronous reset mid-burst.
module tb_icache_responder;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  icache_responder_if #(.BEAT_W(64)) bus ();

  icache_responder #(.SET_BITS(4), .BEAT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Line 0x60 carries w*0x1111_1111 per word; other lines carry {line[15:0], word}.
  function automatic logic [31:0] word_of(input logic [31:0] line, input int w);
    logic [31:0] wv;
    wv = 32'(w);
    if (line == 32'h60) return wv * 32'h1111_1111;
    return {line[15:0], wv[15:0]};
  endfunction

  function automatic logic [63:0] beat_of(input logic [31:0] line, input int k);
    return {word_of(line, 2*k+1), word_of(line, 2*k)};
  endfunction

  // Serves one burst; returns one cycle after the 4th beat (INSTALL cycle).
  task automatic burst(input logic [31:0] line, input int drop_beat, input int inv_beat);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (bus.pmem_read) begin
        found = 1'b1;
        break;
      end
    end
    chk("pmem_read_rise", 64'(found), 64'd1);
    chk("pmem_addr", 64'(bus.pmem_addr), 64'(line));
    for (int k = 0; k < 4; k++) begin
      bus.pmem_rdata = beat_of(line, k);
      bus.pmem_resp  = 1'b1;
      bus.inv        = (k == inv_beat);
      chk("fill_noresp", 64'(bus.i_mem_resp), 64'd0);
      cyc();
      if (k == drop_beat) bus.i_mem_read = 1'b0;
    end
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    bus.inv        = 1'b0;
    #1;
    chk("pmem_read_drop", 64'(bus.pmem_read), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.i_mem_addr = '0;
    bus.i_mem_read = 1'b0;
    bus.inv        = 1'b0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;

    // Reset state
    #3;
    chk("rst_pmem_read", 64'(bus.pmem_read), 64'd0);
    chk("rst_pmem_addr", 64'(bus.pmem_addr), 64'd0);
    chk("rst_resp", 64'(bus.i_mem_resp), 64'd0);
    chk("rst_rdata", 64'(bus.i_mem_rdata), 64'd0);
    #9 rst = 1'b1;

    // Cold miss on 0x60, resp two cycles after the last beat
    cyc();
    bus.i_mem_addr = 32'h60;
    bus.i_mem_read = 1'b1;
    #1;
    chk("cold_miss_resp", 64'(bus.i_mem_resp), 64'd0);
    burst(32'h60, -1, -1);
    chk("cold_install_resp", 64'(bus.i_mem_resp), 64'd0);
    cyc();
    chk("cold_resp", 64'(bus.i_mem_resp), 64'd1);
    chk("cold_rdata", 64'(bus.i_mem_rdata), 64'h0000_0000);
    cyc();
    bus.i_mem_addr = 32'h64;
    #1;
    chk("hit64_resp", 64'(bus.i_mem_resp), 64'd1);
    chk("hit64_rdata", 64'(bus.i_mem_rdata), 64'h1111_1111);

    // Back-to-back hits across the whole line
    for (int w = 0; w < 8; w++) begin
      cyc();
      bus.i_mem_addr = 32'h60 + 32'(4*w);
      #1;
      chk("b2b_resp", 64'(bus.i_mem_resp), 64'd1);
      chk("b2b_rdata", 64'(bus.i_mem_rdata), 64'(word_of(32'h60, w)));
      chk("b2b_pmem_read", 64'(bus.pmem_read), 64'd0);
    end

    // Conflict: 0x260 shares index 3 with 0x60
    cyc();
    bus.i_mem_addr = 32'h260;
    #1;
    chk("conf_miss", 64'(bus.i_mem_resp), 64'd0);
    burst(32'h260, -1, -1);
    cyc();
    chk("conf_hit", 64'(bus.i_mem_resp), 64'd1);
    chk("conf_rdata", 64'(bus.i_mem_rdata), 64'h0260_0000);
    cyc();
    bus.i_mem_addr = 32'h60;
    #1;
    chk("conf_remiss", 64'(bus.i_mem_resp), 64'd0);
    burst(32'h60, -1, -1);
    cyc();
    chk("conf_refill_rdata", 64'(bus.i_mem_rdata), 64'h0000_0000);

    // Fetch dropped mid-fill of 0x80, then a new request for 0x100
    cyc();
    bus.i_mem_addr = 32'h80;
    #1;
    chk("flush_miss", 64'(bus.i_mem_resp), 64'd0);
    burst(32'h80, 1, -1);
    bus.i_mem_addr = 32'h100;
    bus.i_mem_read = 1'b1;
    #1;
    chk("flush_install_resp", 64'(bus.i_mem_resp), 64'd0);
    cyc();
    chk("flush_100_miss", 64'(bus.i_mem_resp), 64'd0);
    burst(32'h100, -1, -1);
    cyc();
    chk("flush_100_resp", 64'(bus.i_mem_resp), 64'd1);
    chk("flush_100_rdata", 64'(bus.i_mem_rdata), 64'h0100_0000);
    cyc();
    bus.i_mem_addr = 32'h88;
    #1;
    chk("flush_80_hit", 64'(bus.i_mem_resp), 64'd1);
    chk("flush_80_rdata", 64'(bus.i_mem_rdata), 64'h0080_0002);

    // inv in IDLE: same-cycle hit still answers, next read misses
    cyc();
    bus.i_mem_addr = 32'h60;
    bus.inv = 1'b1;
    #1;
    chk("inv_same_cycle_resp", 64'(bus.i_mem_resp), 64'd1);
    chk("inv_same_cycle_rdata", 64'(bus.i_mem_rdata), 64'h0000_0000);
    cyc();
    bus.inv = 1'b0;
    #1;
    chk("inv_60_miss", 64'(bus.i_mem_resp), 64'd0);
    burst(32'h60, -1, -1);
    cyc();
    chk("inv_60_refill", 64'(bus.i_mem_resp), 64'd1);

    // inv during the fill of 0xA0: install lands invalid, everything cleared
    cyc();
    bus.i_mem_addr = 32'hA0;
    #1;
    chk("invfill_miss", 64'(bus.i_mem_resp), 64'd0);
    burst(32'hA0, -1, 2);
    cyc();
    chk("invfill_a0_remiss", 64'(bus.i_mem_resp), 64'd0);
    bus.i_mem_addr = 32'h60;
    #1;
    chk("invfill_60_miss", 64'(bus.i_mem_resp), 64'd0);
    bus.i_mem_read = 1'b0;

    // Async reset between beats 2 and 3: burst abandoned, lines invalid
    cyc();
    bus.i_mem_addr = 32'h60;
    bus.i_mem_read = 1'b1;
    #1;
    chk("rstfill_miss", 64'(bus.i_mem_resp), 64'd0);
    cyc();
    chk("rstfill_pmem_read", 64'(bus.pmem_read), 64'd1);
    for (int k = 0; k < 3; k++) begin
      bus.pmem_rdata = beat_of(32'h60, k);
      bus.pmem_resp  = 1'b1;
      cyc();
    end
    bus.pmem_resp = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstfill_drop", 64'(bus.pmem_read), 64'd0);
    chk("rstfill_addr", 64'(bus.pmem_addr), 64'd0);
    #2 rst = 1'b1;
    cyc();
    chk("rstfill_after_miss", 64'(bus.i_mem_resp), 64'd0);
    chk("rstfill_after_rdata", 64'(bus.i_mem_rdata), 64'd0);
    bus.i_mem_read = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
